// File: rtl/golden_nonce_ctrl.sv
// Nonce/cnt sequencer and golden-result queue around the double-SHA-256 transform pair.
// Build option GOLDEN_FIFO_EN: 4-entry result FIFO; otherwise a single holding register.
module golden_nonce_ctrl #(
   parameter int unsigned LOOP      = 6'd4,
   parameter int unsigned NONCE_LAG = 33,
   parameter int unsigned DROP_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       nonce_start,
   input  logic [31:0]       nonce_end,
   input  logic [255:0]      hash_in,
   output logic [5:0]        cnt,
   output logic              feedback,
   output logic [31:0]       nonce,
   output logic              busy,
   output logic              done,
   output logic [31:0]       golden_nonce,
   output logic              golden_valid,
   input  logic              golden_ready,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [5:0]           CNT_LAST = 6'(LOOP - 1);
   localparam int unsigned          LAG_W    = $clog2(NONCE_LAG + 1);
   localparam logic [LAG_W-1:0]     LAG_MAX  = LAG_W'(NONCE_LAG);
   localparam logic [LAG_W-1:0]     LAG_ARM  = LAG_W'(NONCE_LAG - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state, state_next;
   logic [31:0]       nonce_end_q;
   logic [LAG_W-1:0]  warm_q;
   logic [LAG_W-1:0]  drain_q;
   logic              issue_p0;
   logic              hash_strobe_p1;
   logic              warm_armed;
   logic              cand;
   logic [31:0]       cand_nonce;
   logic              push, pop;
   logic              q_full, q_valid;
   logic [31:0]       q_head;
   logic              unused_hash_lo;

   assign busy     = (state == S_RUN) || (state == S_DRAIN);
   assign done     = (state == S_DONE);
   assign feedback = (cnt != 6'd0);
   assign issue_p0 = busy && (cnt == CNT_LAST);
   assign unused_hash_lo = ^hash_in[223:0];

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = S_RUN;
      end else begin
         case (state)
            S_RUN:   if (issue_p0 && (nonce == nonce_end_q)) state_next = S_DRAIN;
            S_DRAIN: if (issue_p0 && (drain_q == LAG_ARM))   state_next = S_DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (start) nonce_end_q <= nonce_end;
   end

   // Stage 0 -> 1: issue schedule, nonce advance, strobe one cycle behind the issue
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= 6'd0;
         nonce          <= 32'd0;
         warm_q         <= '0;
         drain_q        <= '0;
         hash_strobe_p1 <= 1'b0;
      end else if (start) begin
         cnt            <= 6'd0;
         nonce          <= nonce_start;
         warm_q         <= '0;
         drain_q        <= '0;
         hash_strobe_p1 <= 1'b0;
      end else begin
         hash_strobe_p1 <= issue_p0;
         if (busy) cnt <= (cnt == CNT_LAST) ? 6'd0 : cnt + 6'd1;
         if (issue_p0) nonce <= nonce + 32'd1;
         if (hash_strobe_p1 && (warm_q != LAG_MAX)) warm_q <= warm_q + LAG_W'(1);
         if (state != S_DRAIN) drain_q <= '0;
         else if (issue_p0)    drain_q <= drain_q + LAG_W'(1);
      end
   end

   // The strobe that brings the warm-up count to NONCE_LAG carries the hash of nonce_start.
   assign warm_armed = (warm_q >= LAG_ARM);
   assign cand       = hash_strobe_p1 && busy && warm_armed && (hash_in[255:224] == 32'h0);
   assign cand_nonce = nonce - 32'(NONCE_LAG);
   assign pop        = q_valid && golden_ready;
   assign push       = cand && (!q_full || pop);

`ifdef GOLDEN_FIFO_EN
   logic [31:0] fifo_mem [0:3];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  fifo_cnt;

   assign q_full  = (fifo_cnt == 3'd4);
   assign q_valid = (fifo_cnt != 3'd0);
   assign q_head  = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cand_nonce;
   end
`else
   logic        hold_valid;
   logic [31:0] hold_data;

   assign q_full  = hold_valid;
   assign q_valid = hold_valid;
   assign q_head  = hold_data;

   always_ff @(posedge clk) begin
      if (reset)     hold_valid <= 1'b0;
      else if (push) hold_valid <= 1'b1;
      else if (pop)  hold_valid <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) hold_data <= cand_nonce;
   end
`endif

   assign golden_valid = q_valid;
   assign golden_nonce = q_valid ? q_head : 32'd0;

   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt <= '0;
      else if (cand && !push && (drop_cnt != {DROP_W{1'b1}}))
         drop_cnt <= drop_cnt + DROP_W'(1);
   end

endmodule
